// File: rtl/led_phase_sequencer_if.sv
// Tagged per-phase sample stream from the LED phase sequencer to the SpO2 datapath.
// One-cycle sample_valid strobe; frame_done rides along with the last phase of a frame.
interface led_phase_sequencer_if;
  logic       sample_valid;
  logic [1:0] sample_ch;
  logic [7:0] sample_data;
  logic       frame_done;

  modport master (output sample_valid, sample_ch, sample_data, frame_done);
  modport slave  (input  sample_valid, sample_ch, sample_data, frame_done);
endinterface

// File: rtl/led_phase_sequencer.sv
// Time-multiplexes the shared AFE between RED, IR and DARK phases; each phase settles,
// then averages 2^SAMPLE_LOG2 ADC samples into one tagged output sample.
//
// state | meaning
// IDLE  | LEDs off, AFE settings held, shadow copied to active every cycle
// RED_S | RED LED on, red settings applied, ADC ignored for SETTLE cycles
// RED_A | RED acquisition, accumulating ADC samples
// IR_S  | IR LED on, ir settings applied, settle blanking
// IR_A  | IR acquisition
// DRK_S | both LEDs off, ir settings kept, settle blanking
// DRK_A | ambient acquisition
module led_phase_sequencer #(
  parameter int SETTLE      = 3,
  parameter int SAMPLE_LOG2 = 3,
  parameter bit DARK_EN     = 1'b1
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       cfg_load,
  input  logic [6:0] red_dc,
  input  logic [3:0] red_pga,
  input  logic [6:0] ir_dc,
  input  logic [3:0] ir_pga,
  input  logic [7:0] ADC,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic       busy,
  led_phase_sequencer_if.master smp
);

  localparam int NSAMP   = 1 << SAMPLE_LOG2;
  localparam int CNT_MAX = (SETTLE > NSAMP) ? SETTLE : NSAMP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ACC_W   = 8 + SAMPLE_LOG2;
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] ACQ_TC    = CNT_W'(NSAMP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RED_S = 3'd1,
    RED_A = 3'd2,
    IR_S  = 3'd3,
    IR_A  = 3'd4,
    DRK_S = 3'd5,
    DRK_A = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       avg8;

  logic [6:0] sh_red_dc, sh_ir_dc, act_red_dc, act_ir_dc;
  logic [3:0] sh_red_pga, sh_ir_pga, act_red_pga, act_ir_pga;
  logic [6:0] red_dc_ld, ir_dc_ld;
  logic [3:0] red_pga_ld, ir_pga_ld;

  logic       smp_valid, smp_done;
  logic [1:0] smp_ch;
  logic [7:0] smp_data;

  logic last_acq, frame_end, start_red;

  // A cfg_load coinciding with an active-settings update bypasses the shadow.
  assign red_dc_ld  = cfg_load ? red_dc  : sh_red_dc;
  assign red_pga_ld = cfg_load ? red_pga : sh_red_pga;
  assign ir_dc_ld   = cfg_load ? ir_dc   : sh_ir_dc;
  assign ir_pga_ld  = cfg_load ? ir_pga  : sh_ir_pga;

  assign acc_sum = acc + ACC_W'(ADC);
  assign avg8    = 8'(acc_sum >> SAMPLE_LOG2);

  assign last_acq  = (cnt == ACQ_TC);
  assign frame_end = last_acq && ((state == DRK_A) || ((state == IR_A) && !DARK_EN));
  assign start_red = enable && ((state == IDLE) || frame_end);

  assign smp.sample_valid = smp_valid;
  assign smp.sample_ch    = smp_ch;
  assign smp.sample_data  = smp_data;
  assign smp.frame_done   = smp_done;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      sh_red_dc   <= '0;
      sh_red_pga  <= '0;
      sh_ir_dc    <= '0;
      sh_ir_pga   <= '0;
      act_red_dc  <= '0;
      act_red_pga <= '0;
      act_ir_dc   <= '0;
      act_ir_pga  <= '0;
      LED_RED     <= 1'b0;
      LED_IR      <= 1'b0;
      DC_Comp     <= '0;
      PGA_Gain    <= '0;
      busy        <= 1'b0;
      smp_valid   <= 1'b0;
      smp_ch      <= '0;
      smp_data    <= '0;
      smp_done    <= 1'b0;
    end else begin
      smp_valid <= 1'b0;
      smp_done  <= 1'b0;
      if (cfg_load) begin
        sh_red_dc  <= red_dc;
        sh_red_pga <= red_pga;
        sh_ir_dc   <= ir_dc;
        sh_ir_pga  <= ir_pga;
      end

      case (state)
        IDLE: begin
          act_red_dc  <= red_dc_ld;
          act_red_pga <= red_pga_ld;
          act_ir_dc   <= ir_dc_ld;
          act_ir_pga  <= ir_pga_ld;
        end
        RED_S, IR_S, DRK_S: begin
          if (cnt == SETTLE_TC) begin
            cnt   <= '0;
            acc   <= '0;
            state <= (state == RED_S) ? RED_A : (state == IR_S) ? IR_A : DRK_A;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RED_A, IR_A, DRK_A: begin
          if (last_acq) begin
            cnt       <= '0;
            smp_valid <= 1'b1;
            smp_data  <= avg8;
            smp_done  <= frame_end;
            smp_ch    <= (state == RED_A) ? 2'd0 : (state == IR_A) ? 2'd1 : 2'd2;
            if (state == RED_A) begin
              state    <= IR_S;
              LED_RED  <= 1'b0;
              LED_IR   <= 1'b1;
              DC_Comp  <= act_ir_dc;
              PGA_Gain <= act_ir_pga;
            end else if (!frame_end) begin
              state  <= DRK_S;
              LED_IR <= 1'b0;
            end else begin
              state   <= IDLE;
              LED_RED <= 1'b0;
              LED_IR  <= 1'b0;
              busy    <= 1'b0;
            end
          end else begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          LED_RED <= 1'b0;
          LED_IR  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase

      // Frame start overrides the IDLE / frame-end assignments above.
      if (start_red) begin
        state       <= RED_S;
        cnt         <= '0;
        busy        <= 1'b1;
        LED_RED     <= 1'b1;
        LED_IR      <= 1'b0;
        act_red_dc  <= red_dc_ld;
        act_red_pga <= red_pga_ld;
        act_ir_dc   <= ir_dc_ld;
        act_ir_pga  <= ir_pga_ld;
        DC_Comp     <= red_dc_ld;
        PGA_Gain    <= red_pga_ld;
      end
    end
  end

endmodule

// File: tb/tb_led_phase_sequencer.sv
// Self-checking bench for led_phase_sequencer: table-driven frames with a sample scoreboard,
// plus hand-written idle, enable-drop and async-reset sequences.
module tb_led_phase_sequencer;

  localparam int SETTLE = 3;
  localparam int PHASE  = 11;
  localparam int FRAME  = 33;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       cfg_load = 1'b0;
  logic [6:0] red_dc = '0;
  logic [3:0] red_pga = '0;
  logic [6:0] ir_dc = '0;
  logic [3:0] ir_pga = '0;
  logic [7:0] ADC = '0;
  logic       LED_RED, LED_IR, busy;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;

  led_phase_sequencer_if smp_if();

  led_phase_sequencer #(.SETTLE(3), .SAMPLE_LOG2(3), .DARK_EN(1'b1)) dut (
    .CLK(CLK), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load),
    .red_dc(red_dc), .red_pga(red_pga), .ir_dc(ir_dc), .ir_pga(ir_pga),
    .ADC(ADC), .LED_RED(LED_RED), .LED_IR(LED_IR), .DC_Comp(DC_Comp),
    .PGA_Gain(PGA_Gain), .busy(busy), .smp(smp_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int b_r, b_i, b_d;       // ADC level at first acquire cycle per phase
    int ramp;                // ADC increment per acquire cycle
    int settle;              // ADC value during settle cycles
    int e_r, e_i, e_d;       // expected phase averages
    int cfg_at;              // frame cycle to pulse cfg_load (-1 none)
    int c_rdc, c_rpga, c_idc, c_ipga;
    int en_off;              // frame cycle to drop enable (-1 none)
  } vec_t;

  typedef struct {
    int ch;
    int data;
    int fd;
    int due;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sh_rdc = 0, sh_rpga = 0, sh_idc = 0, sh_ipga = 0;
  int act_rdc = 0, act_rpga = 0, act_idc = 0, act_ipga = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (smp_if.sample_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", smp_if.sample_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("valid_cycle", cyc, mon_e.due);
        check("sample_ch", smp_if.sample_ch, mon_e.ch);
        check("sample_data", smp_if.sample_data, mon_e.data);
        check("frame_done", smp_if.frame_done, mon_e.fd);
      end
    end else begin
      check("lone_frame_done", smp_if.frame_done, 0);
      if (sb.size() > 0 && cyc > sb[0].due) begin
        check("missed_valid", smp_if.sample_valid, 1);
        void'(sb.pop_front());
      end
    end
  end

  // Enable must already be high; returns #1 after the last cycle of the frame starts.
  task automatic run_frame(input int vi);
    vec_t v = vecs[vi];
    act_rdc  = sh_rdc;
    act_rpga = sh_rpga;
    act_idc  = sh_idc;
    act_ipga = sh_ipga;
    for (int k = 0; k < FRAME; k++) begin
      int p, pos, b, e;
      @(posedge CLK); #1;
      p   = k / PHASE;
      pos = k % PHASE;
      b   = (p == 0) ? v.b_r : (p == 1) ? v.b_i : v.b_d;
      e   = (p == 0) ? v.e_r : (p == 1) ? v.e_i : v.e_d;
      check("led_red", LED_RED, int'(p == 0));
      check("led_ir", LED_IR, int'(p == 1));
      check("busy", busy, 1);
      check("dc_comp", DC_Comp, (p == 0) ? act_rdc : act_idc);
      check("pga_gain", PGA_Gain, (p == 0) ? act_rpga : act_ipga);
      ADC = (pos < SETTLE) ? 8'(v.settle) : 8'(b + v.ramp * (pos - SETTLE));
      if (pos == PHASE - 1) sb.push_back('{p, e, int'(p == 2), cyc + 1});
      cfg_load = (k == v.cfg_at);
      if (k == v.cfg_at) begin
        red_dc  = 7'(v.c_rdc);
        red_pga = 4'(v.c_rpga);
        ir_dc   = 7'(v.c_idc);
        ir_pga  = 4'(v.c_ipga);
        sh_rdc  = v.c_rdc;
        sh_rpga = v.c_rpga;
        sh_idc  = v.c_idc;
        sh_ipga = v.c_ipga;
      end
      if (v.en_off >= 0 && k >= v.en_off) enable = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d outstanding expected 0", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{200, 100, 20,  0, 0,   200, 100, 20,  -1,  0,  0,   0,  0, -1};
    vecs[1] = '{0,   0,   0,   1, 255, 3,   3,   3,   15,  50, 9,   33, 6, -1};
    vecs[2] = '{255, 255, 255, 0, 0,   255, 255, 255, 32,  77, 12, 100, 15, -1};
    vecs[3] = '{10,  50,  90,  2, 7,   17,  57,  97,  -1,  0,  0,   0,  0, -1};
    vecs[4] = '{1,   0,   248, 1, 0,   4,   3,   251, -1,  0,  0,   0,  0,  5};

    rst_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      check("idle_outputs", {LED_RED, LED_IR, DC_Comp, PGA_Gain, busy,
                             smp_if.sample_ch, smp_if.sample_data}, 0);
    end

    // Load initial settings while idle; outputs must hold until a frame starts.
    red_dc = 7'd40; red_pga = 4'd5; ir_dc = 7'd25; ir_pga = 4'd2;
    sh_rdc = 40; sh_rpga = 5; sh_idc = 25; sh_ipga = 2;
    cfg_load = 1'b1;
    @(posedge CLK); #1 cfg_load = 1'b0;
    @(posedge CLK); #1;
    check("idle_hold_dc", DC_Comp, 0);
    check("idle_hold_pga", PGA_Gain, 0);

    enable = 1'b1;
    for (int vi = 0; vi < 5; vi++) run_frame(vi);
    cfg_load = 1'b0;

    // Last frame dropped enable at cycle 5; it must still complete then go idle.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("post_frame_led_red", LED_RED, 0);
      check("post_frame_led_ir", LED_IR, 0);
      check("post_frame_busy", busy, 0);
    end

    // Async reset in the middle of RED acquisition.
    enable = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge CLK); #1;
      ADC = 8'd99;
    end
    check("pre_reset_led_red", LED_RED, 1);
    #1 rst_n = 1'b0;
    #1;
    check("reset_led_red", LED_RED, 0);
    check("reset_led_ir", LED_IR, 0);
    check("reset_busy", busy, 0);
    check("reset_dc_comp", DC_Comp, 0);
    enable = 1'b0;
    sh_rdc = 0; sh_rpga = 0; sh_idc = 0; sh_ipga = 0;
    repeat (3) @(posedge CLK);
    #1 rst_n = 1'b1;
    @(posedge CLK); #1;
    check("after_reset_busy", busy, 0);

    enable = 1'b1;
    run_frame(0);
    enable = 1'b0;
    @(posedge CLK); #1;
    check("final_busy", busy, 0);
    check("final_led_red", LED_RED, 0);
    repeat (3) @(posedge CLK);
    #1;
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
